image_hue_adjust_pipe: RTL
==========================

Name: image_hue_adjust_pipe

Overview:
- Parametrised, fully pipelined hue-shift stage for the HDMI video path; sits after colour-space/brightness stages and before the output formatter.
- Adjusts the middle-valued channel of each RGB pixel by a signed offset derived from a hue control word, saturating to channel range.
- Adds frame-synchronous configuration shadowing, a mode select (bypass / hue / reverse hue), hsync pass-through, and a registered, latency-matched timing path.

Parameters:
- DW, 8, bits per colour channel; data bus is 3*DW, packed {R,G,B}, R in MSBs.
- CW, 8, width of hue control word.
- CENTER, 100, neutral hue value; offset = hue - CENTER.

Ports:
- i_clk  in  1  pixel clock.
- i_rst_n  in  1  reset; asynchronous, active-low; clock i_clk.
- i_cfg_hue  in  CW  hue control word, unsigned.
- i_cfg_mode  in  2  00 bypass, 01 hue, 10 reverse hue (offset negated), 11 treated as bypass.
- i_cfg_valid  in  1  one-cycle strobe; captures i_cfg_hue/i_cfg_mode into the pending registers.
- i_vs, i_hs, i_de  in  1 each  input timing.
- i_data  in  3*DW  input pixel.
- o_vs, o_hs, o_de  out  1 each  timing delayed by LAT.
- o_data  out  3*DW  processed pixel.
- o_cfg_pending  out  1  high while a captured config has not yet been applied.

Behaviour:
- Reset values:
  - All outputs 0.
  - Pipeline registers 0.
  - Active and pending hue = CENTER; active and pending mode = 00.
  - o_cfg_pending = 0.
- Latency: LAT = 3 cycles, fixed, for o_vs/o_hs/o_de/o_data in every mode, including bypass.
- Config shadowing:
  - i_cfg_valid loads the pending registers and sets o_cfg_pending.
  - Active registers load from pending on an i_vs rising edge (i_vs=1 while the registered i_vs=0); o_cfg_pending clears in the same cycle.
  - If i_cfg_valid coincides with the i_vs rising edge, the strobed values go straight to the active registers and o_cfg_pending stays 0.
  - Repeated strobes before a vs edge: the last strobe wins.
  - Active config never changes mid-frame.
- Stage 1: register pixel and timing; classify channel ordering (strict comparisons). The classification selects the middle channel M and a direction:
  - R>G>B: M=G, +
  - R>B>G: M=B, -
  - G>B>R: M=B, +
  - B>R>G: M=R, +
  - G>R>B: M=R, -
  - B>G>R: M=G, -
  - Any tie between two channels: no adjustment.
- Stage 2: compute M' = M ± off.
  - off = active_hue - CENTER, signed, internal width IW = max(DW,CW)+2.
  - Mode 10 negates off. Mode 00/11 forces off = 0.
  - Non-middle channels pass unchanged.
- Stage 3:
  - Saturate M' to [0, 2^DW-1] (negative → 0; > max → max).
  - Reassemble {R,G,B}.
  - o_data = adjusted pixel when the delayed de = 1; raw delayed input pixel when de = 0.
- Arithmetic: no wrap-around anywhere. All intermediate sums are signed IW bits, which is sufficient for the full hue range 0..2^CW-1.
- Reset mid-frame: pipeline flushes to 0 immediately. Output restarts with valid timing LAT cycles after the first post-reset input.

Decomposition:
- Package image_proc_pkg:
  - Mode constants MODE_BYPASS/MODE_HUE/MODE_HUE_REV.
  - Ordering enum (ORD_NONE plus six orderings).
  - LAT localparam.
  - Channel-select encoding (CH_R/CH_G/CH_B).
- One sub-module, hue_order_classify: combinational comparator block taking three DW-bit channels and returning {ordering, middle-channel select, direction}. It is instantiated in stage 1; its output is registered by the parent.

Test Plan:
- Bypass at reset: DW=8, pixel 0xC86432 with de=1 → o_data 0xC86432 exactly 3 cycles later; o_de/o_hs/o_vs delayed 3.
- Hue +: cfg hue=130, mode=01, applied at vs edge; pixel R=200,G=100,B=50 → 0xC88232 (G=130).
- Saturate + and −:
  - hue=255, pixel R=250,G=240,B=10 → G saturates to 255.
  - hue=0, pixel R=200,G=150,B=30 (R>G>B, M=G, +): G' = 150-100 = 50 → 0xC8321E.
  - hue=0, pixel R=200,G=10,B=90 (R>B>G, M=B, −): B' = 90+100 = 190 → 0xC80ABE.
  - hue=255, pixel R=200,G=10,B=90 → B' = 90-155 = -65 → clamps to 0.
- Shadowing: strobe hue=150 mid-frame → o_cfg_pending=1, output unchanged until the next i_vs rise, then adjustment applies; strobe on the vs-rise cycle → applied that cycle, o_cfg_pending stays 0.
- Ties and blanking: pixel 0x808040 (R=G) → unchanged; de=0 with active hue=200 → raw data passed.
- Reverse mode plus async reset mid-line: mode=10, hue=120, pixel R=200,G=100,B=50 → G=80; assert i_rst_n low → all outputs 0 immediately, config back to CENTER/bypass.

Source files
------------

// File: rtl/image_hue_adjust_pipe_pkg.sv
// Shared definitions for the image processing pipeline stages:
// mode codes, channel-ordering classes and channel-select encoding.
package image_proc_pkg;

    localparam int LAT = 3;

    localparam logic [1:0] MODE_BYPASS  = 2'b00;
    localparam logic [1:0] MODE_HUE     = 2'b01;
    localparam logic [1:0] MODE_HUE_REV = 2'b10;

    // Names list channels from largest to smallest value.
    typedef enum logic [2:0] {
        ORD_NONE,
        ORD_RGB,
        ORD_RBG,
        ORD_GBR,
        ORD_BRG,
        ORD_GRB,
        ORD_BGR
    } order_t;

    typedef enum logic [1:0] {
        CH_R,
        CH_G,
        CH_B
    } ch_sel_t;

endpackage

// File: rtl/image_hue_adjust_pipe_classify.sv
// Combinational ordering classifier: finds the middle-valued channel of a pixel
// and the direction its hue offset is applied in. Any tie yields ORD_NONE.
module hue_order_classify
    import image_proc_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic [DW-1:0] r,
    input  logic [DW-1:0] g,
    input  logic [DW-1:0] b,
    output order_t        ord,
    output ch_sel_t       mid_sel,
    output logic          dir_up
);

    always_comb begin
        ord     = ORD_NONE;
        mid_sel = CH_G;
        dir_up  = 1'b0;
        if (r > g && g > b) begin
            ord = ORD_RGB; mid_sel = CH_G; dir_up = 1'b1;
        end else if (r > b && b > g) begin
            ord = ORD_RBG; mid_sel = CH_B; dir_up = 1'b0;
        end else if (g > b && b > r) begin
            ord = ORD_GBR; mid_sel = CH_B; dir_up = 1'b1;
        end else if (b > r && r > g) begin
            ord = ORD_BRG; mid_sel = CH_R; dir_up = 1'b1;
        end else if (g > r && r > b) begin
            ord = ORD_GRB; mid_sel = CH_R; dir_up = 1'b0;
        end else if (b > g && g > r) begin
            ord = ORD_BGR; mid_sel = CH_G; dir_up = 1'b0;
        end
    end

endmodule

// File: rtl/image_hue_adjust_pipe.sv
// Three-stage hue shift on the middle-valued RGB channel with frame-synchronous config.
// Streaming only: no backpressure, every clock is a pixel slot and i_de qualifies the pixel.
module image_hue_adjust_pipe
    import image_proc_pkg::*;
#(
    parameter int DW     = 8,
    parameter int CW     = 8,
    parameter int CENTER = 100
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [CW-1:0]   i_cfg_hue,
    input  logic [1:0]      i_cfg_mode,
    input  logic            i_cfg_valid,
    input  logic            i_vs,
    input  logic            i_hs,
    input  logic            i_de,
    input  logic [3*DW-1:0] i_data,
    output logic            o_vs,
    output logic            o_hs,
    output logic            o_de,
    output logic [3*DW-1:0] o_data,
    output logic            o_cfg_pending
);

    localparam int PW = 3 * DW;
    localparam int IW = ((DW > CW) ? DW : CW) + 2;
    localparam logic signed [IW-1:0] CH_MAX  = IW'((1 << DW) - 1);
    localparam logic signed [IW-1:0] CEN_S   = IW'(CENTER);
    localparam logic [CW-1:0]        HUE_RST = CW'(CENTER);

    logic [CW-1:0] act_hue, pend_hue;
    logic [1:0]    act_mode, pend_mode;

    logic          s1_vs, s1_hs, s1_de;
    logic [PW-1:0] s1_data;
    order_t        s1_ord;
    ch_sel_t       s1_sel;
    logic          s1_dir;

    logic                 s2_vs, s2_hs, s2_de;
    logic [PW-1:0]        s2_data;
    ch_sel_t              s2_sel;
    logic signed [IW-1:0] s2_sum;

    order_t  c_ord;
    ch_sel_t c_sel;
    logic    c_dir;
    logic    vs_rise;

    assign vs_rise = i_vs & ~s1_vs;

    // Active config only moves on a vs rising edge; a strobe on that same cycle bypasses pending.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            act_hue       <= HUE_RST;
            act_mode      <= MODE_BYPASS;
            pend_hue      <= HUE_RST;
            pend_mode     <= MODE_BYPASS;
            o_cfg_pending <= 1'b0;
        end else if (i_cfg_valid && vs_rise) begin
            act_hue       <= i_cfg_hue;
            act_mode      <= i_cfg_mode;
            pend_hue      <= i_cfg_hue;
            pend_mode     <= i_cfg_mode;
            o_cfg_pending <= 1'b0;
        end else if (vs_rise) begin
            act_hue       <= pend_hue;
            act_mode      <= pend_mode;
            o_cfg_pending <= 1'b0;
        end else if (i_cfg_valid) begin
            pend_hue      <= i_cfg_hue;
            pend_mode     <= i_cfg_mode;
            o_cfg_pending <= 1'b1;
        end
    end

    hue_order_classify #(.DW(DW)) u_classify (
        .r       (i_data[PW-1 -: DW]),
        .g       (i_data[2*DW-1 -: DW]),
        .b       (i_data[DW-1:0]),
        .ord     (c_ord),
        .mid_sel (c_sel),
        .dir_up  (c_dir)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_vs   <= 1'b0;
            s1_hs   <= 1'b0;
            s1_de   <= 1'b0;
            s1_data <= '0;
            s1_ord  <= ORD_NONE;
            s1_sel  <= CH_R;
            s1_dir  <= 1'b0;
        end else begin
            s1_vs   <= i_vs;
            s1_hs   <= i_hs;
            s1_de   <= i_de;
            s1_data <= i_data;
            s1_ord  <= c_ord;
            s1_sel  <= c_sel;
            s1_dir  <= c_dir;
        end
    end

    logic [DW-1:0]        s1_mid;
    logic signed [IW-1:0] off_full, off_eff, mid_ext, mid_sum;

    assign off_full = $signed({{(IW-CW){1'b0}}, act_hue}) - CEN_S;

    always_comb begin
        s1_mid = s1_data[2*DW-1 -: DW];
        case (s1_sel)
            CH_R:    s1_mid = s1_data[PW-1 -: DW];
            CH_G:    s1_mid = s1_data[2*DW-1 -: DW];
            CH_B:    s1_mid = s1_data[DW-1:0];
            default: s1_mid = s1_data[2*DW-1 -: DW];
        endcase
        off_eff = '0;
        if (s1_ord != ORD_NONE) begin
            case (act_mode)
                MODE_HUE:     off_eff = off_full;
                MODE_HUE_REV: off_eff = -off_full;
                default:      off_eff = '0;
            endcase
        end
        mid_ext = $signed({{(IW-DW){1'b0}}, s1_mid});
        mid_sum = s1_dir ? (mid_ext + off_eff) : (mid_ext - off_eff);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s2_vs   <= 1'b0;
            s2_hs   <= 1'b0;
            s2_de   <= 1'b0;
            s2_data <= '0;
            s2_sel  <= CH_R;
            s2_sum  <= '0;
        end else begin
            s2_vs   <= s1_vs;
            s2_hs   <= s1_hs;
            s2_de   <= s1_de;
            s2_data <= s1_data;
            s2_sel  <= s1_sel;
            s2_sum  <= mid_sum;
        end
    end

    logic [DW-1:0] sat_mid;
    logic [PW-1:0] adj;

    always_comb begin
        if (s2_sum < 0)
            sat_mid = '0;
        else if (s2_sum > CH_MAX)
            sat_mid = '1;
        else
            sat_mid = s2_sum[DW-1:0];
        adj = s2_data;
        case (s2_sel)
            CH_R:    adj[PW-1 -: DW]   = sat_mid;
            CH_G:    adj[2*DW-1 -: DW] = sat_mid;
            CH_B:    adj[DW-1:0]       = sat_mid;
            default: adj = s2_data;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_vs   <= 1'b0;
            o_hs   <= 1'b0;
            o_de   <= 1'b0;
            o_data <= '0;
        end else begin
            o_vs   <= s2_vs;
            o_hs   <= s2_hs;
            o_de   <= s2_de;
            o_data <= s2_de ? adj : s2_data;
        end
    end

endmodule
